// File: rtl/au_gray2bin_iter_pkg.sv
// Shared types and helpers for the iterative Gray-to-binary converter.
// Optional macro: AU_GRAY2BIN_ITER_BTB_EN (back-to-back accept in DONE).
package au_gray2bin_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/au_gray2bin_slice.sv
// STEP-bit Gray-to-binary slice; cin is the binary bit just above the slice.
// Purely combinational prefix XOR, MSB first.
module au_gray2bin_slice #(
  parameter int STEP = 2
) (
  input  logic [STEP-1:0] g_s,
  input  logic            cin,
  output logic [STEP-1:0] b_s
);

  logic c;

  always_comb begin
    c   = cin;
    b_s = '0;
    for (int i = STEP - 1; i >= 0; i--) begin
      c      = c ^ g_s[i];
      b_s[i] = c;
    end
  end

endmodule

// File: rtl/au_gray2bin_iter.sv
// Multi-cycle Gray-to-binary converter, STEP bits per cycle, MSB first.
// Optional macro: AU_GRAY2BIN_ITER_BTB_EN (accept in DONE when out_ready).
module au_gray2bin_iter
  import au_gray2bin_iter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] b
);

  localparam int SDIV  = (STEP < 1) ? 1 : STEP;
  localparam int NSTEP = WIDTH / SDIV;
  localparam int CW    = clog2_min1(NSTEP);
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  if (STEP < 1 || STEP > WIDTH || (WIDTH % SDIV) != 0) begin : g_param_chk
    $error("au_gray2bin_iter: bad WIDTH/STEP");
  end

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] opr;
  logic [WIDTH-1:0] b_q;
  logic [STEP-1:0]  b_s;
  logic             accept;
  logic             xfer;
  logic             last;

  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready;
  assign last   = (cnt == LAST);
  assign b      = b_q;

  au_gray2bin_slice #(
    .STEP(STEP)
  ) u_slice (
    .g_s(opr[WIDTH-1 -: STEP]),
    .cin(carry),
    .b_s(b_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (xfer) state_nxt = accept ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == DONE);
`ifdef AU_GRAY2BIN_ITER_BTB_EN
    in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
`else
    in_ready  = (state == IDLE);
`endif
  end

  // Result bits enter from the LSB side so the MSB slice ends up on top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opr   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      opr   <= g;
      cnt   <= '0;
      carry <= 1'b0;
    end else if (state == BUSY) begin
      opr   <= opr << STEP;
      b_q   <= (b_q << STEP) | WIDTH'(b_s);
      carry <= b_s[0];
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_au_gray2bin_iter.sv
// Bench for au_gray2bin_iter: four instances (STEP=1,2,4,8, WIDTH=8)
// share stimulus; a scoreboard checks every transfer against a prefix-XOR model.
module tb_au_gray2bin_iter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] g = '0;
  logic       ir[4];
  logic       ov[4];
  logic [7:0] bq[4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] exp_q[4][$];
  logic       hold[4];
  logic [7:0] hold_b[4];

`ifdef AU_GRAY2BIN_ITER_BTB_EN
  localparam int PERIOD = 5;
`else
  localparam int PERIOD = 6;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    au_gray2bin_iter #(
      .WIDTH(8),
      .STEP(1 << k)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(ir[k]),
      .g(g),
      .out_valid(ov[k]),
      .out_ready(out_ready),
      .b(bq[k])
    );
  end

  // Binary value is the XOR of the Gray word with all its right shifts.
  function automatic logic [7:0] g2b(input logic [7:0] x);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r ^= (x >> i);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic all_idle();
    logic r;
    r = 1'b1;
    for (int k = 0; k < 4; k++) r &= ir[k] & ~ov[k];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!all_idle() && n < 30) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, all_idle()}, 1);
  endtask

  task automatic send(input logic [7:0] gv);
    g = gv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_idle();
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        exp_q[k].delete();
        hold[k] = 1'b0;
        check($sformatf("rst_ov%0d", k), {31'd0, ov[k]}, 0);
        check($sformatf("rst_b%0d", k), {24'd0, bq[k]}, 0);
        check($sformatf("rst_ir%0d", k), {31'd0, ir[k]}, 1);
      end else begin
        if (hold[k]) begin
          check($sformatf("hold_ov%0d", k), {31'd0, ov[k]}, 1);
          check($sformatf("hold_b%0d", k), {24'd0, bq[k]}, {24'd0, hold_b[k]});
        end
        if (ov[k] && out_ready) begin
          if (exp_q[k].size() == 0)
            check($sformatf("spurious_ov%0d", k), {31'd0, ov[k]}, 0);
          else
            check($sformatf("sb_b%0d", k), {24'd0, bq[k]},
                  {24'd0, exp_q[k].pop_front()});
        end
        if (in_valid && ir[k]) exp_q[k].push_back(g2b(g));
        hold[k]   = ov[k] && !out_ready;
        hold_b[k] = bq[k];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int xfers;
    int acc;
    int pulses;
    int last_rise;
    logic [7:0] ops[3];
    logic [7:0] lits[3];
    ops  = '{8'h12, 8'h34, 8'h56};
    lits = '{8'h1C, 8'h27, 8'h64};

    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single operand, latency and handshake
    check("t1_ir", {31'd0, ir[1]}, 1);
    g = 8'hFF;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!ov[1] && lat < 20) begin
      tick();
      lat++;
    end
    check("t1_lat", lat, 4);
    check("t1_b", {24'd0, bq[1]}, 32'hAA);
    tick();
    check("t1_ov_fall", {31'd0, ov[1]}, 0);
    check("t1_ir_after", {31'd0, ir[1]}, 1);
    wait_idle();

    // Directed literal vectors, all STEP values
    send(8'h80);
    for (int k = 0; k < 4; k++) check("t2_80", {24'd0, bq[k]}, 32'hFF);
    send(8'hC0);
    for (int k = 0; k < 4; k++) check("t2_c0", {24'd0, bq[k]}, 32'h80);
    send(8'h00);
    for (int k = 0; k < 4; k++) check("t2_00", {24'd0, bq[k]}, 32'h00);

    // Backpressure with ignored in_valid toggling
    out_ready = 1'b0;
    g = 8'h5A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!ov[1] && lat < 20) begin
      tick();
      lat++;
    end
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid;
      g = 8'($urandom);
      tick();
      check("t3_ov", {31'd0, ov[1]}, 1);
      check("t3_b", {24'd0, bq[1]}, 32'h6C);
      check("t3_ir", {31'd0, ir[1]}, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    xfers = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov[1] && out_ready) xfers++;
    end
    check("t3_xfers", xfers, 1);
    wait_idle();

    // Asynchronous reset in the second BUSY cycle
    g = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t4_ov", {31'd0, ov[1]}, 0);
    check("t4_b", {24'd0, bq[1]}, 0);
    check("t4_ir", {31'd0, ir[1]}, 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h01);
    for (int k = 0; k < 4; k++) check("t4_01", {24'd0, bq[k]}, 32'h01);

    // Exhaustive sweep, checked by the scoreboard
    for (int v = 0; v < 256; v++) send(8'(v));

    // Streaming throughput
    acc = 0;
    pulses = 0;
    last_rise = 0;
    g = ops[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 40 && pulses < 3; n++) begin
      @(negedge clk);
      if (ov[1]) begin
        if (pulses > 0) check("t6_period", cyc - last_rise, PERIOD);
        check("t6_b", {24'd0, bq[1]}, {24'd0, lits[pulses]});
        last_rise = cyc;
        pulses++;
      end
      if (in_valid && ir[1]) begin
        acc++;
        @(posedge clk);
        #1;
        if (acc < 3) g = ops[acc];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("t6_pulses", pulses, 3);
    wait_idle();

    for (int k = 0; k < 4; k++)
      check("sb_drained", exp_q[k].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
